// File: rtl/rb_write_sched.sv
// Write-port scheduler and slot allocator for the 16-entry skip-path Result Buffer.
// Define RB_SCHED_RR_EN for round-robin write arbitration (default: fixed priority Wr0 > Wr1).
module rb_write_sched #(
  parameter int NUM_ENTRIES = 16,
  parameter int IDX_W       = 4,
  parameter int PTR_W       = 2
) (
  input  logic             ClockIn,
  input  logic             AsyncResetIn,
  input  logic             AllocReqIn,
  output logic             AllocGntOut,
  output logic [IDX_W-1:0] AllocIdxOut,
  input  logic             FreeEnIn,
  input  logic [IDX_W-1:0] FreeIdxIn,
  input  logic             Wr0ReqIn,
  input  logic             Wr1ReqIn,
  input  logic [IDX_W-1:0] Wr0IdxIn,
  input  logic [IDX_W-1:0] Wr1IdxIn,
  input  logic [PTR_W-1:0] Wr0PtrIn,
  input  logic [PTR_W-1:0] Wr1PtrIn,
  input  logic [31:0]      Wr0DataIn,
  input  logic [31:0]      Wr1DataIn,
  output logic             Wr0GntOut,
  output logic             Wr1GntOut,
  input  logic             InvReqIn,
  input  logic [PTR_W-1:0] InvPtrIn,
  output logic             InvAckOut,
  output logic             BusyOut,
  output logic             RB_WriteEn,
  output logic             RB_WriteValid,
  output logic [IDX_W-1:0] RB_WriteIdx,
  output logic [PTR_W-1:0] RB_PtrRegId,
  output logic [31:0]      RB_WriteData
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} stateT;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_ENTRIES - 1);

  stateT                  state, stateNxt;
  logic [IDX_W-1:0]       swIdx, swIdxNxt;
  logic [PTR_W-1:0]       invPtr, invPtrNxt;
  logic [NUM_ENTRIES-1:0] alloc;
  logic [NUM_ENTRIES-1:0] tagV;
  logic [PTR_W-1:0]       tag [NUM_ENTRIES];

  logic             anyFree;
  logic [IDX_W-1:0] freeIdx;
  logic             wr0Gnt, wr1Gnt;
  logic             sweepHit;
  logic             cmdEn, cmdValid;
  logic [IDX_W-1:0] cmdIdx;
  logic [PTR_W-1:0] cmdPtr;
  logic [31:0]      cmdData;

`ifdef RB_SCHED_RR_EN
  logic rrLast;
`endif

  // Lowest free slot: scanning downward leaves the smallest free index last.
  always_comb begin
    anyFree = 1'b0;
    freeIdx = '0;
    for (int unsigned i = NUM_ENTRIES; i > 0; i--) begin
      if (!alloc[i-1]) begin
        anyFree = 1'b1;
        freeIdx = IDX_W'(i - 1);
      end
    end
  end

  assign AllocGntOut = AllocReqIn && anyFree;
  assign AllocIdxOut = freeIdx;
  assign Wr0GntOut   = wr0Gnt;
  assign Wr1GntOut   = wr1Gnt;
  assign InvAckOut   = (state == DONE);
  assign BusyOut     = (state != IDLE);

  always_comb begin
    stateNxt  = state;
    swIdxNxt  = swIdx;
    invPtrNxt = invPtr;
    wr0Gnt    = 1'b0;
    wr1Gnt    = 1'b0;
    sweepHit  = 1'b0;
    cmdEn     = 1'b0;
    cmdValid  = 1'b0;
    cmdIdx    = '0;
    cmdPtr    = '0;
    cmdData   = '0;
    unique case (state)
      IDLE: begin
        if (InvReqIn) begin
          stateNxt  = SWEEP;
          swIdxNxt  = '0;
          invPtrNxt = InvPtrIn;
        end else begin
`ifdef RB_SCHED_RR_EN
          if (Wr0ReqIn && Wr1ReqIn) begin
            wr0Gnt = rrLast;
            wr1Gnt = !rrLast;
          end else begin
            wr0Gnt = Wr0ReqIn;
            wr1Gnt = Wr1ReqIn;
          end
`else
          wr0Gnt = Wr0ReqIn;
          wr1Gnt = Wr1ReqIn && !Wr0ReqIn;
`endif
          if (wr0Gnt) begin
            cmdEn    = 1'b1;
            cmdValid = 1'b1;
            cmdIdx   = Wr0IdxIn;
            cmdPtr   = Wr0PtrIn;
            cmdData  = Wr0DataIn;
          end else if (wr1Gnt) begin
            cmdEn    = 1'b1;
            cmdValid = 1'b1;
            cmdIdx   = Wr1IdxIn;
            cmdPtr   = Wr1PtrIn;
            cmdData  = Wr1DataIn;
          end
        end
      end
      SWEEP: begin
        if (tagV[swIdx] && (tag[swIdx] == invPtr)) begin
          sweepHit = 1'b1;
          cmdEn    = 1'b1;
          cmdIdx   = swIdx;
          cmdPtr   = invPtr;
        end
        swIdxNxt = swIdx + 1'b1;
        if (swIdx == LastIdx) stateNxt = DONE;
      end
      DONE: stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge ClockIn or negedge AsyncResetIn) begin
    if (!AsyncResetIn) begin
      state         <= IDLE;
      swIdx         <= '0;
      invPtr        <= '0;
      RB_WriteEn    <= 1'b0;
      RB_WriteValid <= 1'b0;
      RB_WriteIdx   <= '0;
      RB_PtrRegId   <= '0;
      RB_WriteData  <= '0;
    end else begin
      state         <= stateNxt;
      swIdx         <= swIdxNxt;
      invPtr        <= invPtrNxt;
      RB_WriteEn    <= cmdEn;
      RB_WriteValid <= cmdValid;
      RB_WriteIdx   <= cmdIdx;
      RB_PtrRegId   <= cmdPtr;
      RB_WriteData  <= cmdData;
    end
  end

`ifdef RB_SCHED_RR_EN
  always_ff @(posedge ClockIn or negedge AsyncResetIn) begin
    if (!AsyncResetIn)  rrLast <= 1'b1;
    else if (wr0Gnt)    rrLast <= 1'b0;
    else if (wr1Gnt)    rrLast <= 1'b1;
  end
`endif

  // Free is applied last so it wins over a same-cycle write tag to the same slot.
  always_ff @(posedge ClockIn or negedge AsyncResetIn) begin
    if (!AsyncResetIn) begin
      alloc <= '0;
      tagV  <= '0;
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) tag[i] <= '0;
    end else begin
      if (AllocGntOut) alloc[AllocIdxOut] <= 1'b1;
      if (cmdEn && cmdValid) begin
        tag[cmdIdx]  <= cmdPtr;
        tagV[cmdIdx] <= 1'b1;
      end
      if (sweepHit) tagV[swIdx] <= 1'b0;
      if (FreeEnIn && alloc[FreeIdxIn]) begin
        alloc[FreeIdxIn] <= 1'b0;
        tagV[FreeIdxIn]  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rb_write_sched.sv
// Bench for rb_write_sched: directed literal scenarios plus randomized traffic against a cycle model.
`define CHK(n, a, e) chk(n, (32'(a) !== 32'(e)), 32'(a), 32'(e))

module tb_rb_write_sched;
  localparam int N = 16;

  logic        ClockIn = 1'b0;
  logic        AsyncResetIn;
  logic        AllocReqIn, AllocGntOut;
  logic [3:0]  AllocIdxOut;
  logic        FreeEnIn;
  logic [3:0]  FreeIdxIn;
  logic        Wr0ReqIn, Wr1ReqIn;
  logic [3:0]  Wr0IdxIn, Wr1IdxIn;
  logic [1:0]  Wr0PtrIn, Wr1PtrIn;
  logic [31:0] Wr0DataIn, Wr1DataIn;
  logic        Wr0GntOut, Wr1GntOut;
  logic        InvReqIn;
  logic [1:0]  InvPtrIn;
  logic        InvAckOut, BusyOut;
  logic        RB_WriteEn, RB_WriteValid;
  logic [3:0]  RB_WriteIdx;
  logic [1:0]  RB_PtrRegId;
  logic [31:0] RB_WriteData;

  int checks = 0;
  int failures = 0;

  rb_write_sched #(.NUM_ENTRIES(N), .IDX_W(4), .PTR_W(2)) dut (
    .ClockIn(ClockIn), .AsyncResetIn(AsyncResetIn),
    .AllocReqIn(AllocReqIn), .AllocGntOut(AllocGntOut), .AllocIdxOut(AllocIdxOut),
    .FreeEnIn(FreeEnIn), .FreeIdxIn(FreeIdxIn),
    .Wr0ReqIn(Wr0ReqIn), .Wr1ReqIn(Wr1ReqIn), .Wr0IdxIn(Wr0IdxIn), .Wr1IdxIn(Wr1IdxIn),
    .Wr0PtrIn(Wr0PtrIn), .Wr1PtrIn(Wr1PtrIn), .Wr0DataIn(Wr0DataIn), .Wr1DataIn(Wr1DataIn),
    .Wr0GntOut(Wr0GntOut), .Wr1GntOut(Wr1GntOut),
    .InvReqIn(InvReqIn), .InvPtrIn(InvPtrIn), .InvAckOut(InvAckOut), .BusyOut(BusyOut),
    .RB_WriteEn(RB_WriteEn), .RB_WriteValid(RB_WriteValid), .RB_WriteIdx(RB_WriteIdx),
    .RB_PtrRegId(RB_PtrRegId), .RB_WriteData(RB_WriteData)
  );

  always #5 ClockIn = ~ClockIn;

  task automatic chk(input string name, input bit bad, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: slot pool, tag table, and invalidation age (cycles since request accepted).
  bit          mAlloc [N];
  bit          mTagV  [N];
  logic [1:0]  mTag   [N];
  int          mAge;
  logic [1:0]  mInvPtr;
`ifdef RB_SCHED_RR_EN
  bit          mRr;
`endif
  bit          eEn, eValid;
  logic [3:0]  eIdx;
  logic [1:0]  ePtr;
  logic [31:0] eData;

  task automatic modelReset();
    for (int k = 0; k < N; k++) begin
      mAlloc[k] = 0; mTagV[k] = 0; mTag[k] = '0;
    end
    mAge = 0; mInvPtr = '0;
`ifdef RB_SCHED_RR_EN
    mRr = 1;
`endif
    eEn = 0; eValid = 0; eIdx = '0; ePtr = '0; eData = '0;
  endtask

  always @(negedge ClockIn) begin : compare
    bit         eAny, eAllocG, e0, e1, freeHit, nEn, nValid;
    logic [3:0] eFree, nIdx;
    logic [1:0] nPtr;
    logic [31:0] nData;
    int         k;
    if (!AsyncResetIn) begin
      chk("rst_en", RB_WriteEn !== 1'b0, 32'(RB_WriteEn), 32'd0);
      chk("rst_valid", RB_WriteValid !== 1'b0, 32'(RB_WriteValid), 32'd0);
      chk("rst_idx", RB_WriteIdx !== 4'd0, 32'(RB_WriteIdx), 32'd0);
      chk("rst_ptr", RB_PtrRegId !== 2'd0, 32'(RB_PtrRegId), 32'd0);
      chk("rst_data", RB_WriteData !== 32'd0, RB_WriteData, 32'd0);
      chk("rst_busy", BusyOut !== 1'b0, 32'(BusyOut), 32'd0);
      chk("rst_ack", InvAckOut !== 1'b0, 32'(InvAckOut), 32'd0);
      chk("rst_gnt", {AllocGntOut, Wr0GntOut, Wr1GntOut} !== 3'd0,
          32'({AllocGntOut, Wr0GntOut, Wr1GntOut}), 32'd0);
      modelReset();
    end else begin
      eAny = 0; eFree = '0;
      for (int j = N - 1; j >= 0; j--)
        if (!mAlloc[j]) begin eAny = 1; eFree = 4'(j); end
      eAllocG = AllocReqIn && eAny;
      e0 = 0; e1 = 0;
      if (mAge == 0 && !InvReqIn) begin
        if (Wr0ReqIn && Wr1ReqIn) begin
`ifdef RB_SCHED_RR_EN
          e0 = mRr; e1 = !mRr;
`else
          e0 = 1;
`endif
        end else begin
          e0 = Wr0ReqIn; e1 = Wr1ReqIn;
        end
      end
      chk("alloc_gnt", AllocGntOut !== eAllocG, 32'(AllocGntOut), 32'(eAllocG));
      chk("alloc_idx", AllocIdxOut !== eFree, 32'(AllocIdxOut), 32'(eFree));
      chk("wr0_gnt", Wr0GntOut !== e0, 32'(Wr0GntOut), 32'(e0));
      chk("wr1_gnt", Wr1GntOut !== e1, 32'(Wr1GntOut), 32'(e1));
      chk("busy", BusyOut !== (mAge != 0), 32'(BusyOut), 32'(mAge != 0));
      chk("inv_ack", InvAckOut !== (mAge == N + 1), 32'(InvAckOut), 32'(mAge == N + 1));
      chk("rb_en", RB_WriteEn !== eEn, 32'(RB_WriteEn), 32'(eEn));
      if (eEn) begin
        chk("rb_valid", RB_WriteValid !== eValid, 32'(RB_WriteValid), 32'(eValid));
        chk("rb_idx", RB_WriteIdx !== eIdx, 32'(RB_WriteIdx), 32'(eIdx));
        chk("rb_ptr", RB_PtrRegId !== ePtr, 32'(RB_PtrRegId), 32'(ePtr));
        if (eValid) chk("rb_data", RB_WriteData !== eData, RB_WriteData, eData);
      end
      nEn = 0; nValid = 0; nIdx = '0; nPtr = '0; nData = '0;
      if (e0 || e1) begin
        nEn = 1; nValid = 1;
        nIdx  = e0 ? Wr0IdxIn : Wr1IdxIn;
        nPtr  = e0 ? Wr0PtrIn : Wr1PtrIn;
        nData = e0 ? Wr0DataIn : Wr1DataIn;
        mTag[nIdx] = nPtr; mTagV[nIdx] = 1;
`ifdef RB_SCHED_RR_EN
        mRr = e1;
`endif
      end
      if (mAge >= 1 && mAge <= N) begin
        k = mAge - 1;
        if (mTagV[k] && mTag[k] == mInvPtr) begin
          nEn = 1; nValid = 0; nIdx = 4'(k); nPtr = mInvPtr;
          mTagV[k] = 0;
        end
      end
      freeHit = FreeEnIn && mAlloc[FreeIdxIn];
      if (eAllocG) mAlloc[eFree] = 1;
      if (freeHit) begin mAlloc[FreeIdxIn] = 0; mTagV[FreeIdxIn] = 0; end
      if (mAge == 0 && InvReqIn) begin mAge = 1; mInvPtr = InvPtrIn; end
      else if (mAge == N + 1) mAge = 0;
      else if (mAge != 0) mAge++;
      eEn = nEn; eValid = nValid; eIdx = nIdx; ePtr = nPtr; eData = nData;
    end
  end

  task automatic nextCycle();
    @(posedge ClockIn); #1;
  endtask

  task automatic midCycle();
    @(negedge ClockIn); #1;
  endtask

  task automatic idleInputs();
    AllocReqIn = 0; FreeEnIn = 0; FreeIdxIn = '0;
    Wr0ReqIn = 0; Wr1ReqIn = 0; Wr0IdxIn = '0; Wr1IdxIn = '0;
    Wr0PtrIn = '0; Wr1PtrIn = '0; Wr0DataIn = '0; Wr1DataIn = '0;
    InvReqIn = 0; InvPtrIn = '0;
  endtask

  task automatic applyReset();
    idleInputs();
    AsyncResetIn = 0;
    repeat (2) nextCycle();
    AsyncResetIn = 1;
  endtask

  task automatic wr0Once(input logic [3:0] idx, input logic [1:0] ptr, input logic [31:0] data);
    Wr0ReqIn = 1; Wr0IdxIn = idx; Wr0PtrIn = ptr; Wr0DataIn = data;
    nextCycle();
    Wr0ReqIn = 0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    bit invHeld, ackPrev;
    idleInputs();
    AsyncResetIn = 0;
    applyReset();

    // Allocation sweep over the whole pool, then reuse of a freed slot.
    AllocReqIn = 1;
    for (int i = 0; i < 17; i++) begin
      midCycle();
      `CHK("t1_alloc_gnt", AllocGntOut, i < 16);
      `CHK("t1_alloc_idx", AllocIdxOut, (i < 16) ? i : 0);
      nextCycle();
    end
    AllocReqIn = 0; FreeEnIn = 1; FreeIdxIn = 4'd5;
    nextCycle();
    FreeEnIn = 0; AllocReqIn = 1;
    midCycle();
    `CHK("t1_realloc_gnt", AllocGntOut, 1);
    `CHK("t1_realloc_idx", AllocIdxOut, 5);
    nextCycle();
    AllocReqIn = 0;

    // Single write and its registered RB command.
    Wr0ReqIn = 1; Wr0IdxIn = 4'd3; Wr0PtrIn = 2'd1; Wr0DataIn = 32'hDEADBEEF;
    midCycle();
    `CHK("t2_wr0_gnt", Wr0GntOut, 1);
    nextCycle();
    Wr0ReqIn = 0;
    midCycle();
    `CHK("t2_rb_en", RB_WriteEn, 1);
    `CHK("t2_rb_valid", RB_WriteValid, 1);
    `CHK("t2_rb_idx", RB_WriteIdx, 3);
    `CHK("t2_rb_ptr", RB_PtrRegId, 1);
    `CHK("t2_rb_data", RB_WriteData, 32'hDEADBEEF);
    nextCycle();

    // Conflicting writers held for four cycles.
    applyReset();
    Wr0ReqIn = 1; Wr0IdxIn = 4'd1; Wr0DataIn = 32'h11;
    Wr1ReqIn = 1; Wr1IdxIn = 4'd2; Wr1DataIn = 32'h22;
    for (int i = 0; i < 4; i++) begin
      midCycle();
`ifdef RB_SCHED_RR_EN
      `CHK("t3_wr0_gnt", Wr0GntOut, (i % 2) == 0);
      `CHK("t3_wr1_gnt", Wr1GntOut, (i % 2) == 1);
`else
      `CHK("t3_wr0_gnt", Wr0GntOut, 1);
      `CHK("t3_wr1_gnt", Wr1GntOut, 0);
`endif
      nextCycle();
    end
    Wr0ReqIn = 0; Wr1ReqIn = 0;
    nextCycle();

    // Invalidation sweep with a Wr1 request arriving alongside it.
    applyReset();
    wr0Once(4'd2, 2'd2, 32'h2);
    wr0Once(4'd9, 2'd2, 32'h9);
    wr0Once(4'd4, 2'd1, 32'h4);
    nextCycle();
    InvReqIn = 1; InvPtrIn = 2'd2;
    Wr1ReqIn = 1; Wr1IdxIn = 4'd7; Wr1PtrIn = 2'd3; Wr1DataIn = 32'h12345678;
    midCycle();
    `CHK("t4_c0_wr1_gnt", Wr1GntOut, 0);
    for (int cyc = 1; cyc <= 19; cyc++) begin
      nextCycle();
      if (cyc == 18) InvReqIn = 0;
      if (cyc == 19) Wr1ReqIn = 0;
      midCycle();
      if (cyc <= 18) begin
        `CHK("t4_busy", BusyOut, cyc <= 17);
        `CHK("t4_ack", InvAckOut, cyc == 17);
        `CHK("t4_rb_en", RB_WriteEn, (cyc == 4) || (cyc == 11));
        `CHK("t4_wr1_gnt", Wr1GntOut, cyc == 18);
      end
      if (cyc == 4 || cyc == 11) begin
        `CHK("t4_inv_idx", RB_WriteIdx, (cyc == 4) ? 2 : 9);
        `CHK("t4_inv_valid", RB_WriteValid, 0);
        `CHK("t4_inv_ptr", RB_PtrRegId, 2);
      end
      if (cyc == 19) begin
        `CHK("t4_late_en", RB_WriteEn, 1);
        `CHK("t4_late_idx", RB_WriteIdx, 7);
        `CHK("t4_late_data", RB_WriteData, 32'h12345678);
      end
    end
    nextCycle();

    // Reset during a sweep, then a fresh sweep starting from index 0.
    wr0Once(4'd5, 2'd0, 32'hA5A5A5A5);
    nextCycle();
    InvReqIn = 1; InvPtrIn = 2'd0;
    for (int cyc = 1; cyc <= 5; cyc++) nextCycle();
    nextCycle();
    AsyncResetIn = 0; InvReqIn = 0;
    #1;
    `CHK("t5_rst_busy", BusyOut, 0);
    `CHK("t5_rst_en", RB_WriteEn, 0);
    `CHK("t5_rst_ack", InvAckOut, 0);
    nextCycle();
    AsyncResetIn = 1;
    for (int i = 0; i < 20; i++) begin
      midCycle();
      `CHK("t5_quiet_ack", InvAckOut, 0);
      `CHK("t5_quiet_busy", BusyOut, 0);
      nextCycle();
    end
    wr0Once(4'd0, 2'd3, 32'h0BADF00D);
    nextCycle();
    InvReqIn = 1; InvPtrIn = 2'd3;
    for (int cyc = 1; cyc <= 18; cyc++) begin
      nextCycle();
      if (cyc == 18) InvReqIn = 0;
      midCycle();
      `CHK("t5_rb_en", RB_WriteEn, cyc == 2);
      `CHK("t5_ack", InvAckOut, cyc == 17);
      if (cyc == 2) begin
        `CHK("t5_inv_idx", RB_WriteIdx, 0);
        `CHK("t5_inv_valid", RB_WriteValid, 0);
      end
    end
    nextCycle();

    // Randomized traffic; the compare process checks every cycle.
    invHeld = 0; ackPrev = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 1000 == 500) begin
        idleInputs();
        AsyncResetIn = 0; invHeld = 0; ackPrev = 0;
        nextCycle();
        AsyncResetIn = 1;
      end
      if (invHeld && ackPrev) invHeld = 0;
      else if (!invHeld && $urandom_range(0, 39) == 0) begin
        invHeld = 1; InvPtrIn = 2'($urandom);
      end
      InvReqIn   = invHeld;
      AllocReqIn = 1'($urandom);
      FreeEnIn   = ($urandom_range(0, 2) == 0);
      FreeIdxIn  = 4'($urandom);
      Wr0ReqIn   = 1'($urandom);
      Wr1ReqIn   = 1'($urandom);
      Wr0IdxIn   = 4'($urandom);
      Wr1IdxIn   = 4'($urandom);
      Wr0PtrIn   = 2'($urandom);
      Wr1PtrIn   = 2'($urandom);
      Wr0DataIn  = $urandom;
      Wr1DataIn  = $urandom;
      midCycle();
      ackPrev = InvAckOut;
      nextCycle();
    end

    idleInputs();
    repeat (2) nextCycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
